ps2_keyboard_receiver: RTL
==========================

Name: ps2_keyboard_receiver

Overview:
- Decodes PS/2 keyboard serial frames (device-driven ps2_clk/ps2_data) into 8-bit scan codes.
- Sits directly upstream of the keyboard input register and drives its keyboard_input bus and input_arrived_flag strobe.
- That register captures data on the rising edge of input_arrived_flag, so data must be stable before the flag rises, and the flag must be a clean, glitch-free level.

Parameters:
- FILTER_LEN, 4: consecutive equal synchronized samples required before filtered ps2_clk changes.
- TIMEOUT_CYCLES, 100000: clk cycles without a bit edge, while mid-frame, that abort the frame.
- FLAG_CYCLES, 4: clk cycles input_arrived_flag stays high per accepted byte.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- ps2_clk  input  1  raw PS/2 clock line, asynchronous.
- ps2_data  input  1  raw PS/2 data line, asynchronous.
- keyboard_input  output  8  last accepted scan code.
- input_arrived_flag  output  1  high FLAG_CYCLES cycles per accepted byte.
- parity_error  output  1  one-cycle pulse on parity or stop-bit failure.
- frame_error  output  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset, asynchronous on reset_n low:
  - keyboard_input=0x00; input_arrived_flag, parity_error and frame_error = 0.
  - Filtered clk=1, state=IDLE, all counters=0.
  - Reset mid-frame discards the partial frame with no error pulse.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchronizer.
  - Filtered clk toggles only after FILTER_LEN consecutive synced samples differ from its current value.
  - Sample event = filtered clk 1->0. ps2_data is taken from the synced data in the same cycle.
- Frame format: 11 bits = start 0, D0..D7 LSB first, odd parity, stop 1.
- FSM states IDLE, RECEIVE; 4-bit bit_cnt.
- IDLE:
  - Sample with data=0 -> RECEIVE, bit_cnt=1.
  - Sample with data=1 is ignored.
- RECEIVE:
  - Samples bit_cnt 1..8 shift data bits; 9 stores parity; 10 checks stop.
  - At bit 10, valid means XOR(D0..D7, parity)=1 and stop=1.
    - Valid: keyboard_input updates in that cycle. Flag counter loads FLAG_CYCLES; flag rises the next cycle, so data leads the flag by at least 1 clk. State -> IDLE.
    - Invalid: parity_error pulses; keyboard_input and flag are unchanged; state -> IDLE.
- Timeout:
  - Watchdog clears on every sample event and counts only in RECEIVE.
  - Reaching TIMEOUT_CYCLES pulses frame_error and returns to IDLE; no data update.
- Flag generation:
  - Independent down-counter; flag=1 while count != 0; the FSM may receive during the flag.
  - Simultaneous new valid byte while flag high: counter reloads, flag stays high (no extra rising edge). keyboard_input still updates.
- keyboard_input changes only on accepted bytes and holds its value otherwise.
- Errors never raise the flag.

Optional Feature:
- Macro: PS2_BREAK_FILTER_EN.
- Defined:
  - An accepted 0xF0 sets a break_pending bit and produces no keyboard_input update and no flag.
  - The next accepted byte clears break_pending and is also suppressed.
  - Errors or a timeout do not clear break_pending.
  - Only make codes reach downstream.
- Undefined: every accepted byte, including 0xF0 and release codes, updates keyboard_input and raises the flag.

Test Plan:
- Valid frame 0x1C (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1), 10 kHz ps2_clk -> keyboard_input=0x1C at least 1 clk before flag rises; flag high exactly 4 cycles; no errors.
- 0x1C with parity=1 after prior 0x29 -> parity_error single-cycle pulse; keyboard_input stays 0x29; flag stays 0.
- Start + 4 bits, then clock idle > 100000 cycles -> frame_error pulse once; a following valid 0x29 frame decodes correctly.
- 2-clk low glitch on ps2_clk in IDLE and mid-frame, FILTER_LEN=4 -> no sample taken; frame still decodes 0x1C.
- reset_n low at bit 5 of a frame, released, then valid 0x5A -> outputs 0 during reset, no error pulses, keyboard_input=0x5A with one flag.
- Sequence 0x1C, 0xF0, 0x1C:
  - Macro defined: one flag, keyboard_input=0x1C.
  - Macro undefined: three flags, final keyboard_input=0x1C, with 0xF0 observed in between.

Source files
------------

// File: rtl/ps2_keyboard_receiver_if.sv
// PS/2 receiver bus: raw device lines in, scan code / strobe / error pulses out.
// master = PS/2 device side (drives the lines), slave = the receiver.
interface ps2_keyboard_receiver_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] keyboard_input;
   logic       input_arrived_flag;
   logic       parity_error;
   logic       frame_error;

   modport master (
      output ps2_clk, ps2_data,
      input  keyboard_input, input_arrived_flag, parity_error, frame_error
   );
   modport slave (
      input  ps2_clk, ps2_data,
      output keyboard_input, input_arrived_flag, parity_error, frame_error
   );
endinterface

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 keyboard frame decoder: sync + glitch filter, 11-bit frame FSM, watchdog, flag strobe.
// Optional PS2_BREAK_FILTER_EN: swallow 0xF0 and the release code that follows it.
module ps2_keyboard_receiver #(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int FLAG_CYCLES    = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   ps2_keyboard_receiver_if.slave ps2
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GW = $clog2(FLAG_CYCLES + 1);

   localparam logic [0:0] IDLE    = 1'b0;
   localparam logic [0:0] RECEIVE = 1'b1;

   // bit 0 = ps2_clk, bit 1 = ps2_data; lines idle high
   logic [1:0]    meta_q, meta_d, sync_q, sync_d;
   logic          filt_q, filt_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          sample, sdata;

   logic [0:0]    state_q, state_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [TW-1:0] wdog_q, wdog_d;
   logic [7:0]    kbd_q, kbd_d;
   logic          perr_q, perr_d;
   logic          ferr_q, ferr_d;
   logic [GW-1:0] flag_cnt_q, flag_cnt_d;
   logic          flag_q, flag_d;
   logic          good, accept;
`ifdef PS2_BREAK_FILTER_EN
   logic          bp_q, bp_d;
`endif

   always_comb begin
      meta_d = {ps2.ps2_data, ps2.ps2_clk};
      sync_d = meta_q;
   end

   // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples
   always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      sample = 1'b0;
      if (sync_q[0] != filt_q) begin
         if (fcnt_q == FW'(FILTER_LEN - 1)) begin
            filt_d = sync_q[0];
            sample = filt_q;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end
   end

   assign sdata = sync_q[1];

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      wdog_d    = '0;
      perr_d    = 1'b0;
      ferr_d    = 1'b0;
      good      = 1'b0;
      case (state_q)
         IDLE: begin
            if (sample && !sdata) begin
               state_d   = RECEIVE;
               bit_cnt_d = 4'd1;
            end
         end
         default: begin
            if (sample) begin
               if (bit_cnt_q <= 4'd8) begin
                  shift_d   = {sdata, shift_q[7:1]};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (bit_cnt_q == 4'd9) begin
                  par_d     = sdata;
                  bit_cnt_d = 4'd10;
               end else begin
                  state_d   = IDLE;
                  bit_cnt_d = 4'd0;
                  if ((^shift_q ^ par_q) && sdata) good   = 1'b1;
                  else                             perr_d = 1'b1;
               end
            end else if (wdog_q == TW'(TIMEOUT_CYCLES - 1)) begin
               ferr_d    = 1'b1;
               state_d   = IDLE;
               bit_cnt_d = 4'd0;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
      endcase
   end

`ifdef PS2_BREAK_FILTER_EN
   always_comb begin
      bp_d   = bp_q;
      accept = 1'b0;
      if (good) begin
         if (bp_q)                  bp_d   = 1'b0;
         else if (shift_q == 8'hF0) bp_d   = 1'b1;
         else                       accept = 1'b1;
      end
   end
`else
   assign accept = good;
`endif

   // Flag is registered off the counter so it trails the data by a cycle and
   // cannot glitch; a reload while high keeps it high instead of re-pulsing.
   always_comb begin
      kbd_d      = accept ? shift_q : kbd_q;
      flag_cnt_d = flag_cnt_q;
      if (accept)                flag_cnt_d = GW'(FLAG_CYCLES);
      else if (flag_cnt_q != '0) flag_cnt_d = flag_cnt_q - 1'b1;
      flag_d = (flag_cnt_q != '0) || (accept && flag_q);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_q     <= 2'b11;
         sync_q     <= 2'b11;
         filt_q     <= 1'b1;
         fcnt_q     <= '0;
         state_q    <= IDLE;
         bit_cnt_q  <= 4'd0;
         shift_q    <= 8'h00;
         par_q      <= 1'b0;
         wdog_q     <= '0;
         kbd_q      <= 8'h00;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         flag_cnt_q <= '0;
         flag_q     <= 1'b0;
      end else begin
         meta_q     <= meta_d;
         sync_q     <= sync_d;
         filt_q     <= filt_d;
         fcnt_q     <= fcnt_d;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         wdog_q     <= wdog_d;
         kbd_q      <= kbd_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         flag_cnt_q <= flag_cnt_d;
         flag_q     <= flag_d;
      end
   end

`ifdef PS2_BREAK_FILTER_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) bp_q <= 1'b0;
      else          bp_q <= bp_d;
   end
`endif

   assign ps2.keyboard_input     = kbd_q;
   assign ps2.input_arrived_flag = flag_q;
   assign ps2.parity_error       = perr_q;
   assign ps2.frame_error        = ferr_q;

endmodule
